adc_capture_writer: RTL and testbench
=====================================

Name: adc_capture_writer

Overview:
Sits upstream of the 5120x10 ADC sample RAM and is the only writer of that RAM during capture. On a start request it waits for a level trigger on the incoming ADC stream, then writes CAPTURE_LEN optionally decimated samples to RAM addresses 0..CAPTURE_LEN-1. It then holds the buffer as "full" until the downstream FFT/demod stage releases it. Logical addresses 0..5119 map directly onto the RAM address bus: 0..4095 have ad[12]=0; 4096..5119 have ad[12]=1 with ad[11:10]=0.

Parameters:
DATA_W, 10, ADC sample width and RAM data width
ADDR_W, 13, RAM address width
CAPTURE_LEN, 5120, samples per capture (1..5120)
DECIM, 1, store every DECIM-th valid sample (>=1)
MIDSCALE, 512, ADC zero level used by the trigger comparator

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
adc_data  in  DATA_W  ADC sample, offset binary
adc_valid  in  1  one-cycle strobe marking adc_data valid; may be high every cycle
start  in  1  one-cycle pulse arming a capture
abort  in  1  one-cycle pulse cancelling arm/capture
release  in  1  one-cycle pulse from consumer returning the buffer
threshold  in  DATA_W  trigger level, compared against |adc_data-MIDSCALE|
ram_ce  out  1  RAM clock enable for the write port
ram_wre  out  1  RAM write enable
ram_ad  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
busy  out  1  high in WAIT_TRIG or CAPTURE
done  out  1  high in FULL; the consumer owns the RAM
wr_count  out  ADDR_W  samples written in the current capture

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all outputs 0, decimation counter 0. Reset during CAPTURE stops writes from the next edge and discards the partial capture.
- States: IDLE, WAIT_TRIG, CAPTURE, FULL.
- IDLE: on start, go to WAIT_TRIG and clear wr_count. Ignore release and abort.
- WAIT_TRIG: compute mag = |adc_data - MIDSCALE| on DATA_W+1 bits, unsigned.
  - On an adc_valid cycle with mag >= threshold, go to CAPTURE. That sample is stored at address 0 and the decimation counter is zeroed.
  - threshold=0 triggers on the first valid sample.
- CAPTURE: a valid sample is stored when the decimation counter is 0. The counter increments per valid sample and wraps at DECIM-1.
- Write timing (registered): a store at edge N gives, during cycle N+1, ram_ce=1, ram_wre=1, ram_ad=write index, ram_din=sample. Latency from adc_valid is 1 cycle.
- ram_ce/ram_wre are 0 in every cycle without a store. Back-to-back stores are allowed (1 per cycle).
- wr_count increments with each store and equals the next write index.
- When the store of index CAPTURE_LEN-1 occurs, go to FULL. done=1 from the following cycle, wr_count=CAPTURE_LEN.
- FULL: no writes; done held. On release go to IDLE, done=0 next cycle, wr_count held. start is ignored until release.
- abort in WAIT_TRIG/CAPTURE: go to IDLE. Any store coincident with abort is suppressed. busy=0 next cycle.
- Same-cycle priority: reset > abort > release > trigger/store > start.
- start while busy or done is ignored (no restart).
- ram_ad never exceeds CAPTURE_LEN-1. Addresses 4096..5119 are emitted as {1'b1,2'b00,idx[9:0]}, which equals idx numerically.

Optional Feature:
ADC_TWOS_COMP_EN
- Defined: ram_din = adc_data with MSB inverted (offset binary to two's complement, e.g. 512->0x000, 0->0x200). The trigger still uses raw adc_data.
- Undefined: ram_din = adc_data unchanged.

Test Plan:
- reset held 3 cycles mid-CAPTURE -> ram_ce=ram_wre=busy=done=0, wr_count=0; next start requires a fresh trigger.
- threshold=100, samples 560,600,612 (valid every cycle) -> no trigger on 560/600 (mag 48/88); 612 (mag 100) stored at ad=0 one cycle later; next sample stored at ad=1.
- CAPTURE_LEN=5120, DECIM=1, ramp data -> ad 4095 = 0x0FFF, ad 4096 = 0x1000, ad 5119 = 0x13FF; done=1 the cycle after the last write; exactly 5120 write pulses.
- DECIM=4, CAPTURE_LEN=8, 32 valid samples after trigger -> samples 0,4,...,28 written to ad 0..7; done after the 8th write.
- abort coincident with the 10th store -> no write for that sample; busy=0 next cycle; start then re-arms with wr_count=0.
- In FULL: start ignored, no writes; release -> done=0 next cycle; new start accepted the cycle after.
- ADC_TWOS_COMP_EN defined, adc_data=0x3FF stored -> ram_din=0x1FF; undefined -> ram_din=0x3FF.

Source files
------------

// File: rtl/adc_capture_writer.sv
// adc_capture_writer: the only writer of the 5120x10 ADC sample RAM during capture.
// When armed, it waits for a level trigger on the ADC stream.
// It then stores CAPTURE_LEN samples, optionally decimated, at addresses 0..CAPTURE_LEN-1.
// It holds the buffer as full until the consumer releases it.
// Optional feature macro: ADC_TWOS_COMP_EN.
//   When defined, stored samples are converted from offset binary to two's complement.
//   The trigger still uses the raw sample.
// The consumer's release pulse arrives on buf_release, because "release" is a reserved word.
// Logical addresses 4096..5119 already have the form {1'b1,2'b00,idx[9:0]}.
// The write index is therefore driven onto ram_ad unchanged.
module adc_capture_writer #(
   parameter int DATA_W      = 10,
   parameter int ADDR_W      = 13,
   parameter int CAPTURE_LEN = 5120,
   parameter int DECIM       = 1,
   parameter int MIDSCALE    = 512
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] adc_data,
   input  logic              adc_valid,
   input  logic              start,
   input  logic              abort,
   input  logic              buf_release,
   input  logic [DATA_W-1:0] threshold,
   output logic              ram_ce,
   output logic              ram_wre,
   output logic [ADDR_W-1:0] ram_ad,
   output logic [DATA_W-1:0] ram_din,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] wr_count
);

   typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, FULL} state_t;

   localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CNT_W-1:0]  DECIM_LAST = CNT_W'(DECIM - 1);
   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(CAPTURE_LEN - 1);
   localparam logic [DATA_W:0]   MID        = (DATA_W + 1)'(MIDSCALE);

   state_t            state;
   state_t            next_state;
   logic [CNT_W-1:0]  decim_cnt;
   logic [DATA_W:0]   sample_ext;
   logic [DATA_W:0]   mag;
   logic              trig_hit;
   logic              store;
   logic              trig_fire;
   logic [DATA_W-1:0] store_data;

   // Trigger magnitude |adc_data - MIDSCALE| on one extra bit, and the value written to RAM
   always_comb begin
      sample_ext = {1'b0, adc_data};
      mag        = (sample_ext >= MID) ? (sample_ext - MID) : (MID - sample_ext);
      trig_hit   = adc_valid && (mag >= {1'b0, threshold});
`ifdef ADC_TWOS_COMP_EN
      store_data = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};
`else
      store_data = adc_data;
`endif
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state and store decision; abort outranks any store in the same cycle
   always_comb begin
      next_state = state;
      store      = 1'b0;
      trig_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (start)
               next_state = WAIT_TRIG;
         end
         WAIT_TRIG: begin
            if (abort) begin
               next_state = IDLE;
            end else if (trig_hit) begin
               store      = 1'b1;
               trig_fire  = 1'b1;
               next_state = (LAST_IDX == '0) ? FULL : CAPTURE;
            end
         end
         CAPTURE: begin
            if (abort) begin
               next_state = IDLE;
            end else if (adc_valid && (decim_cnt == '0)) begin
               store = 1'b1;
               if (wr_count == LAST_IDX)
                  next_state = FULL;
            end
         end
         FULL: begin
            if (buf_release)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Registered RAM write port, write index and decimation counter
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_ce    <= 1'b0;
         ram_wre   <= 1'b0;
         ram_ad    <= '0;
         ram_din   <= '0;
         wr_count  <= '0;
         decim_cnt <= '0;
      end else begin
         ram_ce  <= store;
         ram_wre <= store;
         if (store) begin
            ram_ad   <= wr_count;
            ram_din  <= store_data;
            wr_count <= wr_count + ADDR_W'(1);
         end
         if ((state == IDLE) && start)
            wr_count <= '0;
         // The trigger sample occupies decimation slot 0, so counting resumes at slot 1
         if (trig_fire)
            decim_cnt <= (DECIM_LAST == '0) ? '0 : CNT_W'(1);
         else if ((state == CAPTURE) && adc_valid && !abort)
            decim_cnt <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + CNT_W'(1);
      end
   end

   assign busy = (state == WAIT_TRIG) || (state == CAPTURE);
   assign done = (state == FULL);

endmodule

// File: tb/tb_adc_capture_writer.sv
// Directed bench for adc_capture_writer.
// The main instance uses a full 5120-sample capture with no decimation.
// A second instance uses an 8-sample capture with DECIM=4.
module tb_adc_capture_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  adc_data;
   logic        adc_valid;
   logic        start;
   logic        abort;
   logic        buf_release;
   logic [9:0]  threshold;
   logic        ram_ce;
   logic        ram_wre;
   logic [12:0] ram_ad;
   logic [9:0]  ram_din;
   logic        busy;
   logic        done;
   logic [12:0] wr_count;

   logic [9:0]  d_data;
   logic        d_valid;
   logic        d_start;
   logic        d_abort;
   logic        d_release;
   logic [9:0]  d_threshold;
   logic        d_ram_ce;
   logic        d_ram_wre;
   logic [12:0] d_ram_ad;
   logic [9:0]  d_ram_din;
   logic        d_busy;
   logic        d_done;
   logic [12:0] d_wr_count;

   int nCompared   = 0;
   int nMismatched = 0;
   int wrPulses    = 0;
   int dWrPulses   = 0;

   always #5 clk = ~clk;

   adc_capture_writer #(.DATA_W(10), .ADDR_W(13), .CAPTURE_LEN(5120), .DECIM(1), .MIDSCALE(512)) dut (
      .clk(clk), .reset(reset), .adc_data(adc_data), .adc_valid(adc_valid),
      .start(start), .abort(abort), .buf_release(buf_release), .threshold(threshold),
      .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad), .ram_din(ram_din),
      .busy(busy), .done(done), .wr_count(wr_count)
   );

   adc_capture_writer #(.DATA_W(10), .ADDR_W(13), .CAPTURE_LEN(8), .DECIM(4), .MIDSCALE(512)) dut_d (
      .clk(clk), .reset(reset), .adc_data(d_data), .adc_valid(d_valid),
      .start(d_start), .abort(d_abort), .buf_release(d_release), .threshold(d_threshold),
      .ram_ce(d_ram_ce), .ram_wre(d_ram_wre), .ram_ad(d_ram_ad), .ram_din(d_ram_din),
      .busy(d_busy), .done(d_done), .wr_count(d_wr_count)
   );

   // Count write pulses on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (ram_ce && ram_wre)
         wrPulses++;
      if (d_ram_ce && d_ram_wre)
         dWrPulses++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] expDin(input logic [9:0] d);
`ifdef ADC_TWOS_COMP_EN
      return {~d[9], d[8:0]};
`else
      return d;
`endif
   endfunction

   // Drive one cycle of main-instance inputs, then return pulses to idle just after the edge
   task automatic applyStimulus(input logic v, input logic [9:0] d, input logic s,
                                input logic ab, input logic rel);
      adc_valid   = v;
      adc_data    = d;
      start       = s;
      abort       = ab;
      buf_release = rel;
      @(posedge clk);
      #1;
      adc_valid   = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      buf_release = 1'b0;
   endtask

   initial begin
      int base;
      int bad;
      logic [9:0] d;
      logic [12:0] idx;
      logic [9:0] twosExp;

      reset = 1'b1;
      adc_data = '0; adc_valid = 1'b0; start = 1'b0; abort = 1'b0; buf_release = 1'b0;
      threshold = '0;
      d_data = '0; d_valid = 1'b0; d_start = 1'b0; d_abort = 1'b0; d_release = 1'b0;
      d_threshold = '0;
      $display("[TB] start");

      // Power-on reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_ce", ram_ce, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_wrcnt", wr_count, 0);
      reset = 1'b0;

      // Trigger threshold 100: 560 and 600 fall short, 612 triggers
      threshold = 10'd100;
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("arm_busy", busy, 1);
      checkOutput("arm_wrcnt", wr_count, 0);
      applyStimulus(1, 10'd560, 0, 0, 0);
      checkOutput("no_trig_560", ram_ce, 0);
      applyStimulus(1, 10'd600, 0, 0, 0);
      checkOutput("no_trig_600", ram_ce, 0);
      applyStimulus(1, 10'd612, 0, 0, 0);
      checkOutput("trig_ce", ram_ce, 1);
      checkOutput("trig_wre", ram_wre, 1);
      checkOutput("trig_ad", ram_ad, 0);
      checkOutput("trig_din", ram_din, expDin(10'd612));
      checkOutput("trig_wrcnt", wr_count, 1);
      applyStimulus(1, 10'd700, 0, 0, 0);
      checkOutput("second_ad", ram_ad, 1);
      checkOutput("second_din", ram_din, expDin(10'd700));
      applyStimulus(0, 10'd1, 0, 0, 0);
      checkOutput("idle_ce", ram_ce, 0);
      applyStimulus(1, 10'd300, 0, 0, 0);
      checkOutput("cap_below_thr_ad", ram_ad, 2);
      checkOutput("cap_below_thr_ce", ram_ce, 1);

      // Reset held for 3 cycles in the middle of a capture
      reset = 1'b1;
      applyStimulus(1, 10'd650, 0, 0, 0);
      applyStimulus(1, 10'd651, 0, 0, 0);
      applyStimulus(1, 10'd652, 0, 0, 0);
      checkOutput("midrst_ce", ram_ce, 0);
      checkOutput("midrst_wre", ram_wre, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_wrcnt", wr_count, 0);
      reset = 1'b0;
      applyStimulus(0, 0, 1, 0, 0);
      applyStimulus(1, 10'd512, 0, 0, 0);
      checkOutput("rearm_needs_trig", ram_ce, 0);
      checkOutput("rearm_busy", busy, 1);

      // Abort coincident with the 10th store
      applyStimulus(1, 10'd612, 0, 0, 0);
      for (int i = 1; i < 9; i++)
         applyStimulus(1, 10'(100 + i), 0, 0, 0);
      checkOutput("pre_abort_ad", ram_ad, 8);
      checkOutput("pre_abort_wrcnt", wr_count, 9);
      applyStimulus(1, 10'd200, 0, 1, 0);
      checkOutput("abort_ce", ram_ce, 0);
      checkOutput("abort_busy", busy, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("abort_rearm_busy", busy, 1);
      checkOutput("abort_rearm_wrcnt", wr_count, 0);

      // Full 5120-sample ramp, threshold 0 triggers on the first sample
      threshold = '0;
      base = wrPulses;
      bad = 0;
      for (int i = 0; i < 5120; i++) begin
         idx = 13'(i);
         d = idx[9:0];
         applyStimulus(1, d, 0, 0, 0);
         if (ram_ce !== 1'b1 || ram_ad !== idx || ram_din !== expDin(d))
            bad++;
         if (i == 4095) checkOutput("ramp_ad_4095", ram_ad, 32'h0FFF);
         if (i == 4096) checkOutput("ramp_ad_4096", ram_ad, 32'h1000);
         if (i == 5118) checkOutput("ramp_done_early", done, 0);
         if (i == 5119) begin
            checkOutput("ramp_ad_5119", ram_ad, 32'h13FF);
            checkOutput("ramp_done", done, 1);
            checkOutput("ramp_busy", busy, 0);
            checkOutput("ramp_wrcnt", wr_count, 5120);
         end
      end
      checkOutput("ramp_bad_writes", bad, 0);

      // FULL: start and samples are ignored
      applyStimulus(1, 10'd5, 1, 0, 0);
      checkOutput("full_ce", ram_ce, 0);
      checkOutput("full_done", done, 1);
      applyStimulus(1, 10'd6, 1, 0, 0);
      checkOutput("full_start_ignored", busy, 0);
      checkOutput("ramp_pulses", wrPulses - base, 5120);
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("release_done", done, 0);
      checkOutput("release_wrcnt", wr_count, 5120);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("post_release_busy", busy, 1);
      checkOutput("post_release_wrcnt", wr_count, 0);

      // Stored-data format for full-scale 0x3FF
`ifdef ADC_TWOS_COMP_EN
      twosExp = 10'h1FF;
`else
      twosExp = 10'h3FF;
`endif
      applyStimulus(1, 10'h3FF, 0, 0, 0);
      checkOutput("fmt_ce", ram_ce, 1);
      checkOutput("fmt_din", ram_din, twosExp);
      applyStimulus(0, 0, 0, 1, 0);

      // Decimating instance: DECIM=4 and 8 samples, 32 valid samples starting with the trigger
      base = dWrPulses;
      d_start = 1'b1;
      @(posedge clk);
      #1;
      d_start = 1'b0;
      checkOutput("d_arm_busy", d_busy, 1);
      for (int k = 0; k < 32; k++) begin
         d_valid = 1'b1;
         d_data  = 10'(100 + k);
         @(posedge clk);
         #1;
         if (k % 4 == 0) begin
            checkOutput($sformatf("d_ce_%0d", k), d_ram_ce, 1);
            checkOutput($sformatf("d_ad_%0d", k), d_ram_ad, k / 4);
            checkOutput($sformatf("d_din_%0d", k), d_ram_din, expDin(10'(100 + k)));
         end else begin
            checkOutput($sformatf("d_ce_%0d", k), d_ram_ce, 0);
         end
         if (k == 24) checkOutput("d_done_early", d_done, 0);
         if (k == 28) checkOutput("d_done", d_done, 1);
      end
      d_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("d_pulses", dWrPulses - base, 8);
      checkOutput("d_wrcnt", d_wr_count, 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
